// File: rtl/cpu8_pkg.sv
// ============================================================================
//  Module   : cpu8_pkg
//  Brief    : Shared opcodes, FSM states, jump conditions and helpers for cpu8.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu8_pkg;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_LDI    = 4'h1;
    localparam logic [3:0] OP_MOV    = 4'h2;
    localparam logic [3:0] OP_LD     = 4'h3;
    localparam logic [3:0] OP_ST     = 4'h4;
    localparam logic [3:0] OP_ADD    = 4'h5;
    localparam logic [3:0] OP_SUB    = 4'h6;
    localparam logic [3:0] OP_AND    = 4'h7;
    localparam logic [3:0] OP_OR     = 4'h8;
    localparam logic [3:0] OP_XOR    = 4'h9;
    localparam logic [3:0] OP_CMP    = 4'hA;
    localparam logic [3:0] OP_INCDEC = 4'hB;
    localparam logic [3:0] OP_JMP    = 4'hC;
    localparam logic [3:0] OP_CALL   = 4'hD;
    localparam logic [3:0] OP_STK    = 4'hE;
    localparam logic [3:0] OP_SYS    = 4'hF;

    localparam logic [1:0] JC_ALWAYS = 2'b00;
    localparam logic [1:0] JC_Z      = 2'b01;
    localparam logic [1:0] JC_NZ     = 2'b10;
    localparam logic [1:0] JC_C      = 2'b11;

    localparam logic [7:0] SP_INIT_DEFAULT = 8'hFF;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_OPERAND = 2'd1,
        ST_EXEC    = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    // Instructions that carry an immediate/address byte after the opcode.
    function automatic logic is_two_byte(input logic [3:0] op, input logic [1:0] rs);
        return (op == OP_LDI) || (op == OP_LD) || (op == OP_ST) || (op == OP_JMP) ||
               ((op == OP_CALL) && (rs == 2'b00));
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu8_alu.sv
// ============================================================================
//  Module   : cpu8_alu
//  Brief    : Combinational 8-bit ALU producing result, zero and carry/borrow.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu8_alu
    import cpu8_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] op,
    output logic [7:0] result,
    output logic       z,
    output logic       c
);

    logic [8:0] w_sum;

    assign w_sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        result = a;
        c      = 1'b0;
        case (op)
            OP_ADD: begin
                result = w_sum[7:0];
                c      = w_sum[8];
            end
            OP_SUB, OP_CMP: begin
                result = a - b;
                c      = (a < b);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: result = a;
        endcase
        z = (result == 8'h00);
    end

endmodule

`default_nettype wire

// File: rtl/cpu8_core.sv
// ============================================================================
//  Module   : cpu8_core
//  Brief    : Multi-cycle 8-bit CPU with 256-byte unified RAM and stack.
//             Define CPU_ILLEGAL_TRAP_EN to trap on reserved encodings.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu8_core
    import cpu8_pkg::*;
#(
    parameter logic [7:0] SP_INIT   = SP_INIT_DEFAULT,
    parameter int         MEM_DEPTH = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       prog_we,
    input  logic [7:0] prog_addr,
    input  logic [7:0] prog_data,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       halted,
    output logic       trap
);

    state_t     r_state;
    logic [7:0] r_pc;
    logic [7:0] r_sp;
    logic [7:0] r_ir;
    logic [7:0] r_opnd;
    logic [7:0] r_regs [0:3];
    logic       r_z;
    logic       r_c;
    logic [7:0] r_out_data;
    logic       r_out_valid;
    logic       r_halted;
    logic [7:0] r_mem [0:MEM_DEPTH-1];

    logic [3:0] w_op;
    logic [1:0] w_rd;
    logic [1:0] w_rs;
    logic [7:0] w_rd_val;
    logic [7:0] w_rs_val;
    logic [7:0] w_fetch_byte;
    logic [7:0] w_sp_inc;
    logic [7:0] w_pop_byte;
    logic [7:0] w_ld_byte;
    logic       w_reserved;
    logic       w_exec;
    logic       w_flag_op;
    logic       w_jump_taken;
    logic [3:0] w_alu_op;
    logic [7:0] w_alu_b;
    logic [7:0] w_alu_res;
    logic       w_alu_z;
    logic       w_alu_c;
    logic       w_mem_we;
    logic [7:0] w_mem_addr;
    logic [7:0] w_mem_wdata;

    assign w_op         = r_ir[7:4];
    assign w_rd         = r_ir[3:2];
    assign w_rs         = r_ir[1:0];
    assign w_rd_val     = r_regs[w_rd];
    assign w_rs_val     = r_regs[w_rs];
    assign w_fetch_byte = r_mem[r_pc];
    assign w_sp_inc     = r_sp + 8'd1;
    assign w_pop_byte   = r_mem[w_sp_inc];
    assign w_ld_byte    = r_mem[r_opnd];
    assign w_exec       = (r_state == ST_EXEC) && run;

    // Sub-op groups B/D/E/F only define rs=00 and rs=01.
    assign w_reserved = ((w_op == OP_INCDEC) || (w_op == OP_CALL) ||
                         (w_op == OP_STK) || (w_op == OP_SYS)) && w_rs[1];

    assign w_flag_op = ((w_op >= OP_ADD) && (w_op <= OP_CMP)) ||
                       ((w_op == OP_INCDEC) && !w_rs[1]);

    always_comb begin
        w_alu_op = w_op;
        w_alu_b  = w_rs_val;
        if (w_op == OP_INCDEC) begin
            w_alu_b  = 8'd1;
            w_alu_op = w_rs[0] ? OP_SUB : OP_ADD;
        end
    end

    always_comb begin
        case (w_rd)
            JC_ALWAYS: w_jump_taken = 1'b1;
            JC_Z:      w_jump_taken = r_z;
            JC_NZ:     w_jump_taken = !r_z;
            default:   w_jump_taken = r_c;
        endcase
    end

    cpu8_alu u_alu (
        .a      (w_rd_val),
        .b      (w_alu_b),
        .op     (w_alu_op),
        .result (w_alu_res),
        .z      (w_alu_z),
        .c      (w_alu_c)
    );

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = r_sp;
        w_mem_wdata = w_rd_val;
        if (w_exec && !w_reserved) begin
            case (w_op)
                OP_ST: begin
                    w_mem_we   = 1'b1;
                    w_mem_addr = r_opnd;
                end
                OP_CALL: begin
                    w_mem_we    = (w_rs == 2'b00);
                    w_mem_wdata = r_pc;
                end
                OP_STK:  w_mem_we = (w_rs == 2'b00);
                default: w_mem_we = 1'b0;
            endcase
        end
    end

    // RAM keeps its contents through reset; the CPU port wins over loading.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end else if (!run && prog_we) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

`ifdef CPU_ILLEGAL_TRAP_EN
    logic r_trap;
    assign trap = r_trap;
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_FETCH;
            r_pc        <= 8'h00;
            r_sp        <= SP_INIT;
            r_ir        <= 8'h00;
            r_opnd      <= 8'h00;
            r_z         <= 1'b0;
            r_c         <= 1'b0;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
            r_halted    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= 8'h00;
            end
`ifdef CPU_ILLEGAL_TRAP_EN
            r_trap      <= 1'b0;
`endif
        end else begin
            r_out_valid <= 1'b0;
            if (run) begin
                case (r_state)
                    ST_FETCH: begin
                        r_ir    <= w_fetch_byte;
                        r_pc    <= r_pc + 8'd1;
                        r_state <= is_two_byte(w_fetch_byte[7:4], w_fetch_byte[1:0]) ?
                                   ST_OPERAND : ST_EXEC;
                    end
                    ST_OPERAND: begin
                        r_opnd  <= w_fetch_byte;
                        r_pc    <= r_pc + 8'd1;
                        r_state <= ST_EXEC;
                    end
                    ST_EXEC: begin
                        r_state <= ST_FETCH;
                        if (w_reserved) begin
`ifdef CPU_ILLEGAL_TRAP_EN
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                            r_trap   <= 1'b1;
`endif
                        end else begin
                            if (w_flag_op) begin
                                r_z <= w_alu_z;
                                r_c <= w_alu_c;
                            end
                            case (w_op)
                                OP_LDI: r_regs[w_rd] <= r_opnd;
                                OP_MOV: r_regs[w_rd] <= w_rs_val;
                                OP_LD:  r_regs[w_rd] <= w_ld_byte;
                                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_INCDEC:
                                    r_regs[w_rd] <= w_alu_res;
                                OP_JMP: begin
                                    if (w_jump_taken) r_pc <= r_opnd;
                                end
                                OP_CALL: begin
                                    if (w_rs[0]) begin
                                        r_pc <= w_pop_byte;
                                        r_sp <= w_sp_inc;
                                    end else begin
                                        r_pc <= r_opnd;
                                        r_sp <= r_sp - 8'd1;
                                    end
                                end
                                OP_STK: begin
                                    if (w_rs[0]) begin
                                        r_regs[w_rd] <= w_pop_byte;
                                        r_sp         <= w_sp_inc;
                                    end else begin
                                        r_sp <= r_sp - 8'd1;
                                    end
                                end
                                OP_SYS: begin
                                    if (w_rs[0]) begin
                                        r_out_data  <= w_rd_val;
                                        r_out_valid <= 1'b1;
                                    end else begin
                                        r_state  <= ST_HALT;
                                        r_halted <= 1'b1;
                                    end
                                end
                                default: r_pc <= r_pc;
                            endcase
                        end
                    end
                    default: r_state <= ST_HALT;
                endcase
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign halted    = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_cpu8_core.sv
// ============================================================================
//  Module   : tb_cpu8_core
//  Brief    : Self-checking bench for cpu8_core: directed program table,
//             hand-written corner sequences and random programs vs an ISA model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu8_core;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic       prog_we = 1'b0;
    logic [7:0] prog_addr = 8'h00;
    logic [7:0] prog_data = 8'h00;
    logic [7:0] out_data;
    logic       out_valid;
    logic       halted;
    logic       trap;

    cpu8_core dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .halted    (halted),
        .trap      (trap)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_out;
    logic [7:0] image [256];

    // Instruction-level reference machine
    logic [7:0] m_mem [256];
    logic [7:0] m_r [4];
    logic [7:0] m_pc, m_sp, m_last;
    logic       m_z, m_c, m_halt, m_trap;
    int         m_nout, m_cycles;

    typedef struct {
        string      name;
        int         len;
        logic [255:0] prog;
        int         cycles;
        int         exp_nout;
        logic [7:0] exp_out;
        logic [7:0] exp_pc;
        logic [7:0] exp_sp;
        logic       exp_halt;
        logic       exp_trap;
        logic [31:0] exp_regs;
        logic [1:0] exp_zc;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        run   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load_image();
        run = 1'b0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            prog_we   = 1'b1;
            prog_addr = i[7:0];
            prog_data = image[i];
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic run_cycles(input int n);
        n_out = 0;
        run   = 1'b1;
        repeat (n) begin
            @(negedge clk);
            if (out_valid) n_out++;
        end
        run = 1'b0;
    endtask

    task automatic fill_image(input int k);
        for (int j = 0; j < 256; j++) begin
            if (j < vecs[k].len) image[j] = vecs[k].prog[8*(vecs[k].len-1-j) +: 8];
            else                 image[j] = 8'h00;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = image[i];
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
        m_pc = 8'h00; m_sp = 8'hFF; m_z = 1'b0; m_c = 1'b0;
        m_halt = 1'b0; m_trap = 1'b0; m_nout = 0; m_last = 8'h00; m_cycles = 0;
    endtask

    task automatic model_run(input int max_instr, input int max_cycles);
        logic [7:0] ir, opnd, a, b, res;
        logic [3:0] op;
        logic [1:0] rd, rs;
        int         s;
        bit         two, resv, taken;
        int         n = 0;
        while (!m_halt && n < max_instr && m_cycles < max_cycles) begin
            ir = m_mem[m_pc];
            m_pc = m_pc + 8'd1;
            op = ir[7:4]; rd = ir[3:2]; rs = ir[1:0];
            two = (op == 4'h1) || (op == 4'h3) || (op == 4'h4) || (op == 4'hC) ||
                  (op == 4'hD && rs == 2'd0);
            opnd = 8'h00;
            if (two) begin
                opnd = m_mem[m_pc];
                m_pc = m_pc + 8'd1;
                m_cycles += 3;
            end else begin
                m_cycles += 2;
            end
            a = m_r[rd];
            b = m_r[rs];
            resv = (op == 4'hB || op == 4'hD || op == 4'hE || op == 4'hF) && rs[1];
            if (resv) begin
`ifdef CPU_ILLEGAL_TRAP_EN
                m_halt = 1'b1;
                m_trap = 1'b1;
`endif
            end else begin
                case (op)
                    4'h1: m_r[rd] = opnd;
                    4'h2: m_r[rd] = b;
                    4'h3: m_r[rd] = m_mem[opnd];
                    4'h4: m_mem[opnd] = a;
                    4'h5: begin
                        s = int'(a) + int'(b);
                        m_c = (s > 255); res = s[7:0]; m_z = (res == 0); m_r[rd] = res;
                    end
                    4'h6, 4'hA: begin
                        s = int'(a) - int'(b) + 256;
                        m_c = (a < b); res = s[7:0]; m_z = (res == 0);
                        if (op == 4'h6) m_r[rd] = res;
                    end
                    4'h7, 4'h8, 4'h9: begin
                        res = (op == 4'h7) ? (a & b) : (op == 4'h8) ? (a | b) : (a ^ b);
                        m_c = 1'b0; m_z = (res == 0); m_r[rd] = res;
                    end
                    4'hB: begin
                        if (rs == 2'd0) begin m_c = (a == 8'hFF); res = a + 8'd1; end
                        else            begin m_c = (a == 8'h00); res = a - 8'd1; end
                        m_z = (res == 0); m_r[rd] = res;
                    end
                    4'hC: begin
                        taken = (rd == 2'd0) || (rd == 2'd1 && m_z) ||
                                (rd == 2'd2 && !m_z) || (rd == 2'd3 && m_c);
                        if (taken) m_pc = opnd;
                    end
                    4'hD: begin
                        if (rs == 2'd0) begin
                            m_mem[m_sp] = m_pc; m_sp = m_sp - 8'd1; m_pc = opnd;
                        end else begin
                            m_sp = m_sp + 8'd1; m_pc = m_mem[m_sp];
                        end
                    end
                    4'hE: begin
                        if (rs == 2'd0) begin
                            m_mem[m_sp] = a; m_sp = m_sp - 8'd1;
                        end else begin
                            m_sp = m_sp + 8'd1; m_r[rd] = m_mem[m_sp];
                        end
                    end
                    4'hF: begin
                        if (rs == 2'd0) m_halt = 1'b1;
                        else begin m_last = a; m_nout++; end
                    end
                    default: ;
                endcase
            end
            n++;
        end
    endtask

    task automatic compare_state(input string tag);
        int bad = 0;
        check({tag, ".pc"}, dut.r_pc, m_pc);
        check({tag, ".sp"}, dut.r_sp, m_sp);
        check({tag, ".regs"}, {dut.r_regs[3], dut.r_regs[2], dut.r_regs[1], dut.r_regs[0]},
              {m_r[3], m_r[2], m_r[1], m_r[0]});
        check({tag, ".zc"}, {dut.r_z, dut.r_c}, {m_z, m_c});
        check({tag, ".halted"}, halted, m_halt);
        check({tag, ".trap"}, trap, m_trap);
        check({tag, ".nout"}, n_out, m_nout);
        check({tag, ".out_data"}, out_data, m_last);
        for (int i = 0; i < 256; i++) if (dut.r_mem[i] !== m_mem[i]) bad++;
        check({tag, ".mem_diffs"}, bad, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{name:"add", len:7, prog:{8'h10,8'h05,8'h14,8'h03,8'h51,8'hF1,8'hF0},
                    cycles:12, exp_nout:1, exp_out:8'h08, exp_pc:8'h07, exp_sp:8'hFF,
                    exp_halt:1'b1, exp_trap:1'b0, exp_regs:32'h0000_0308, exp_zc:2'b00};
        vecs[1] = '{name:"wrap", len:5, prog:{8'h10,8'hFF,8'hB0,8'hC4,8'h20},
                    cycles:8, exp_nout:0, exp_out:8'h00, exp_pc:8'h20, exp_sp:8'hFF,
                    exp_halt:1'b0, exp_trap:1'b0, exp_regs:32'h0000_0000, exp_zc:2'b11};
        vecs[2] = '{name:"loop", len:7, prog:{8'h14,8'h03,8'hB5,8'hC8,8'h02,8'hF5,8'hF0},
                    cycles:22, exp_nout:1, exp_out:8'h00, exp_pc:8'h07, exp_sp:8'hFF,
                    exp_halt:1'b1, exp_trap:1'b0, exp_regs:32'h0000_0000, exp_zc:2'b10};
        vecs[3] = '{name:"stack", len:10,
                    prog:{8'h18,8'hAA,8'hE8,8'hD0,8'h09,8'hED,8'hFD,8'hF0,8'h00,8'hD1},
                    cycles:16, exp_nout:1, exp_out:8'hAA, exp_pc:8'h08, exp_sp:8'hFF,
                    exp_halt:1'b1, exp_trap:1'b0, exp_regs:32'hAAAA_0000, exp_zc:2'b00};
`ifdef CPU_ILLEGAL_TRAP_EN
        vecs[4] = '{name:"illegal", len:5, prog:{8'h10,8'h77,8'hF3,8'hF1,8'hF0},
                    cycles:9, exp_nout:0, exp_out:8'h00, exp_pc:8'h03, exp_sp:8'hFF,
                    exp_halt:1'b1, exp_trap:1'b1, exp_regs:32'h0000_0077, exp_zc:2'b00};
`else
        vecs[4] = '{name:"illegal", len:5, prog:{8'h10,8'h77,8'hF3,8'hF1,8'hF0},
                    cycles:9, exp_nout:1, exp_out:8'h77, exp_pc:8'h05, exp_sp:8'hFF,
                    exp_halt:1'b1, exp_trap:1'b0, exp_regs:32'h0000_0077, exp_zc:2'b00};
`endif

        // Reset state
        do_reset();
        check("reset.pc", dut.r_pc, 8'h00);
        check("reset.sp", dut.r_sp, 8'hFF);
        check("reset.outs", {out_data, out_valid, halted, trap}, 11'h000);

        // Directed program table
        for (int k = 0; k < 5; k++) begin
            do_reset();
            fill_image(k);
            load_image();
            model_reset();
            model_run(1000, vecs[k].cycles);
            run_cycles(vecs[k].cycles);
            check({vecs[k].name, ".nout"}, n_out, vecs[k].exp_nout);
            check({vecs[k].name, ".out_data"}, out_data, vecs[k].exp_out);
            check({vecs[k].name, ".pc"}, dut.r_pc, vecs[k].exp_pc);
            check({vecs[k].name, ".sp"}, dut.r_sp, vecs[k].exp_sp);
            check({vecs[k].name, ".halted"}, halted, vecs[k].exp_halt);
            check({vecs[k].name, ".trap"}, trap, vecs[k].exp_trap);
            check({vecs[k].name, ".regs"},
                  {dut.r_regs[3], dut.r_regs[2], dut.r_regs[1], dut.r_regs[0]},
                  vecs[k].exp_regs);
            check({vecs[k].name, ".zc"}, {dut.r_z, dut.r_c}, vecs[k].exp_zc);
            compare_state({vecs[k].name, ".model"});
        end

        // Latency: HLT lands on cycle 12 exactly, and run is ignored afterwards
        do_reset();
        fill_image(0);
        load_image();
        run_cycles(11);
        check("lat.halted_at_11", halted, 1'b0);
        check("lat.nout_at_11", n_out, 1);
        run_cycles(1);
        check("lat.halted_at_12", halted, 1'b1);
        run_cycles(5);
        check("lat.pc_in_halt", dut.r_pc, 8'h07);
        check("lat.nout_in_halt", n_out, 0);

        // Freeze for 10 cycles mid-program, then resume
        do_reset();
        load_image();
        run_cycles(4);
        n_out = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) n_out++;
        end
        check("freeze.pc", dut.r_pc, 8'h03);
        check("freeze.r0", dut.r_regs[0], 8'h05);
        check("freeze.nout", n_out, 0);
        run_cycles(8);
        check("freeze.resume_nout", n_out, 1);
        check("freeze.resume_out", out_data, 8'h08);
        check("freeze.resume_halted", halted, 1'b1);

        // Reset asserted while the OUT instruction sits in EXEC
        do_reset();
        load_image();
        run_cycles(9);
        run   = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        check("midreset.pc", dut.r_pc, 8'h00);
        check("midreset.sp", dut.r_sp, 8'hFF);
        check("midreset.halted", halted, 1'b0);
        check("midreset.out_valid", out_valid, 1'b0);
        reset = 1'b0;
        run   = 1'b0;

        // Random memory images against the reference model
        for (int t = 0; t < 16; t++) begin
            do_reset();
            for (int j = 0; j < 256; j++) image[j] = 8'($urandom);
            load_image();
            model_reset();
            model_run(40, 1 << 30);
            run_cycles(m_cycles);
            compare_state($sformatf("rand%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
